// File: rtl/keychain_pkg.sv
// keychain_pkg: shared FSM state type and frame/bit-timing helpers for keychain_host.
package keychain_pkg;
  typedef enum logic [1:0] {IDLE, SEND, RECV, DONE} state_e;
  function automatic int clks_per_bit(input int clk_hz, input int baud_rate);
    return clk_hz / baud_rate;
  endfunction
  function automatic int frame_bytes(input int msg_bytes, input int key_bytes);
    return msg_bytes + 2 * key_bytes;
  endfunction
endpackage

// File: rtl/uart_byte_rx.sv
// uart_byte_rx: 8N1 receiver with synchronizer, false-start rejection and mid-bit sampling.
module uart_byte_rx #(
  parameter int CPB = 10
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       en_i,
  input  logic       rx_i,
  output logic       valid_o,
  output logic       err_o,
  output logic [7:0] data_o
);
  localparam int CW = $clog2(CPB + 1);
  localparam logic [1:0] R_IDLE = 2'd0, R_START = 2'd1, R_DATA = 2'd2, R_STOP = 2'd3;
  logic sync1_q, sync2_q, prev_q, fall, half, full;
  logic [1:0] st_q, st_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] data_q, data_d;
  always_comb begin
    fall = en_i && prev_q && !sync2_q;
    half = cnt_q == CW'(CPB / 2 - 1);
    full = cnt_q == CW'(CPB - 1);
    st_d = st_q;
    cnt_d = cnt_q + CW'(1);
    bit_d = bit_q;
    data_d = data_q;
    if (st_q == R_IDLE) begin
      cnt_d = '0;
      st_d = fall ? R_START : R_IDLE;
    end else if (st_q == R_START) begin
      if (half) begin
        cnt_d = '0;
        bit_d = '0;
        st_d = sync2_q ? R_IDLE : R_DATA;
      end
    end else if (st_q == R_DATA) begin
      if (full) begin
        cnt_d = '0;
        data_d = {sync2_q, data_q[7:1]};
        bit_d = bit_q + 3'd1;
        st_d = (bit_q == 3'd7) ? R_STOP : R_DATA;
      end
    end else if (full) begin
      cnt_d = '0;
      st_d = R_IDLE;
    end
  end
  assign valid_o = st_q == R_STOP && full && sync2_q;
  assign err_o = st_q == R_STOP && full && !sync2_q;
  assign data_o = data_q;
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      sync1_q <= rx_i;
      sync2_q <= sync1_q;
      prev_q <= sync2_q;
    end
  end
  // Leaving the receive window abandons any byte in flight.
  always_ff @(posedge clk_in) begin
    if (!rst_in || !en_i) begin
      st_q <= R_IDLE;
      cnt_q <= '0;
      bit_q <= '0;
      data_q <= '0;
    end else begin
      st_q <= st_d;
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      data_q <= data_d;
    end
  end
endmodule

// File: rtl/keychain_host.sv
// keychain_host: sends message/exponent/modulus over UART and collects the result with timeout.
module keychain_host
  import keychain_pkg::*;
#(
  parameter int KEY_BYTES    = 4,
  parameter int MSG_BYTES    = 2,
  parameter int BAUD_RATE    = 115_200,
  parameter int CLK_HZ       = 100_000_000,
  parameter int TIMEOUT_BITS = 40
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   start_in,
  input  logic [8*MSG_BYTES-1:0] message_in,
  input  logic [8*KEY_BYTES-1:0] exponent_in,
  input  logic [8*KEY_BYTES-1:0] modulus_in,
  output logic                   busy_out,
  output logic                   valid_out,
  output logic                   error_out,
  output logic [8*KEY_BYTES-1:0] result_out,
  output logic                   tx_wire_out,
  input  logic                   rx_wire_in
);
  localparam int CPB = clks_per_bit(CLK_HZ, BAUD_RATE);
  localparam int N = frame_bytes(MSG_BYTES, KEY_BYTES);
  localparam int FW = 8 * N;
  localparam int KW = 8 * KEY_BYTES;
  localparam int TO = TIMEOUT_BITS * CPB;
  localparam int CW = $clog2(CPB + 1);
  localparam int BW = $clog2(N + 1);
  localparam int TW = $clog2(TO + 1);
  state_e state_q, state_d;
  logic [FW-1:0] frame_q, frame_d;
  logic [KW-1:0] shift_q, shift_d, result_q, result_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0] bit_q, bit_d;
  logic [BW-1:0] byte_q, byte_d;
  logic [TW-1:0] to_q, to_d;
  logic valid_q, valid_d, err_q, err_d, tx_q, tx_d;
  logic [7:0] cur_byte, rx_data;
  logic [2:0] cur_bit;
  logic rx_valid, rx_err;
  uart_byte_rx #(.CPB(CPB)) u_rx (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .en_i    (state_q == RECV),
    .rx_i    (rx_wire_in),
    .valid_o (rx_valid),
    .err_o   (rx_err),
    .data_o  (rx_data)
  );
  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    shift_d = shift_q;
    result_d = result_q;
    cnt_d = cnt_q;
    bit_d = bit_q;
    byte_d = byte_q;
    to_d = to_q;
    valid_d = 1'b0;
    err_d = 1'b0;
    if (state_q == IDLE) begin
      if (start_in) begin
        state_d = SEND;
        frame_d = {message_in, exponent_in, modulus_in};
        cnt_d = '0;
        bit_d = '0;
        byte_d = '0;
      end
    end else if (state_q == SEND) begin
      cnt_d = cnt_q + CW'(1);
      if (cnt_q == CW'(CPB - 1)) begin
        cnt_d = '0;
        bit_d = bit_q + 4'd1;
        if (bit_q == 4'd9) begin
          bit_d = '0;
          frame_d = frame_q << 8;
          byte_d = byte_q + BW'(1);
          if (byte_q == BW'(N - 1)) begin
            state_d = RECV;
            byte_d = '0;
            to_d = '0;
            shift_d = '0;
          end
        end
      end
    end else if (state_q == RECV) begin
      to_d = to_q + TW'(1);
      if (rx_valid) begin
        to_d = '0;
        shift_d = KW'({shift_q, rx_data});
        byte_d = byte_q + BW'(1);
        if (byte_q == BW'(KEY_BYTES - 1)) begin
          state_d = DONE;
          valid_d = 1'b1;
          result_d = KW'({shift_q, rx_data});
        end
      end else if (rx_err || to_q == TW'(TO - 1)) begin
        state_d = IDLE;
        err_d = 1'b1;
        shift_d = '0;
        byte_d = '0;
      end
    end else begin
      state_d = IDLE;
      shift_d = '0;
      byte_d = '0;
    end
    // Line level is derived from next state so it changes on the same edge as the FSM.
    cur_byte = frame_d[FW-1 -: 8];
    cur_bit = 3'(bit_d - 4'd1);
    tx_d = state_d != SEND || bit_d == 4'd9 || (bit_d != 4'd0 && cur_byte[cur_bit]);
  end
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q <= IDLE;
      frame_q <= '0;
      shift_q <= '0;
      result_q <= '0;
      cnt_q <= '0;
      bit_q <= '0;
      byte_q <= '0;
      to_q <= '0;
      valid_q <= 1'b0;
      err_q <= 1'b0;
      tx_q <= 1'b1;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      shift_q <= shift_d;
      result_q <= result_d;
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      byte_q <= byte_d;
      to_q <= to_d;
      valid_q <= valid_d;
      err_q <= err_d;
      tx_q <= tx_d;
    end
  end
  assign busy_out = state_q != IDLE;
  assign valid_out = valid_q;
  assign error_out = err_q;
  assign result_out = result_q;
  assign tx_wire_out = tx_q;
endmodule

// File: tb/tb_keychain_host.sv
// tb_keychain_host: directed scenarios with tx-byte and result scoreboards for keychain_host.
module tb_keychain_host;
  logic clk = 1'b0, rst_in = 1'b0, start_in = 1'b0, rx_wire_in = 1'b1;
  logic [15:0] message_in = '0;
  logic [31:0] exponent_in = '0, modulus_in = '0;
  logic busy_out, valid_out, error_out, tx_wire_out;
  logic [31:0] result_out;
  int checks = 0, errors = 0, cyc = 0, c0 = 0, valid_seen = 0, err_seen = 0;
  int e0, v0, n;
  logic tx_prev = 1'b1, valid_prev = 1'b0, mon_en = 1'b1;
  logic [8:0] txq[$];
  logic [31:0] resq[$];

  keychain_host #(
    .KEY_BYTES(4), .MSG_BYTES(2), .BAUD_RATE(100_000), .CLK_HZ(1_000_000), .TIMEOUT_BITS(40)
  ) dut (
    .clk_in(clk), .rst_in(rst_in), .start_in(start_in), .message_in(message_in),
    .exponent_in(exponent_in), .modulus_in(modulus_in), .busy_out(busy_out),
    .valid_out(valid_out), .error_out(error_out), .result_out(result_out),
    .tx_wire_out(tx_wire_out), .rx_wire_in(rx_wire_in)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic [15:0] m, input logic [31:0] e, input logic [31:0] d);
    logic [79:0] f;
    f = {m, e, d};
    @(negedge clk);
    message_in = m; exponent_in = e; modulus_in = d; start_in = 1'b1;
    for (int i = 0; i < 10; i++) txq.push_back({i == 0, f[79-8*i -: 8]});
    @(negedge clk);
    start_in = 1'b0;
    c0 = cyc;
    chk("start_busy", busy_out, 1);
    chk("start_tx_low", tx_wire_out, 0);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx_wire_in = 1'b0;
    repeat (10) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_wire_in = b[i];
      repeat (10) @(negedge clk);
    end
    rx_wire_in = stop;
    repeat (10) @(negedge clk);
    rx_wire_in = 1'b1;
  endtask

  task automatic wait_tx_done();
    int k = 0;
    while (txq.size() != 0 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    chk("tx_drain", txq.size(), 0);
  endtask

  task automatic wait_busy_low();
    int k = 0;
    while (busy_out && k < 2000) begin
      @(negedge clk);
      k++;
    end
    chk("busy_fall", busy_out, 0);
  endtask

  // Line decoder: mid-bit samples every byte and checks it against the expected frame.
  initial begin
    logic [7:0] b;
    logic s0, s1;
    logic [8:0] e;
    int st, last_st;
    last_st = 0;
    forever begin
      @(negedge clk);
      if (rst_in && tx_prev && !tx_wire_out) begin
        st = cyc;
        repeat (5) @(negedge clk);
        s0 = tx_wire_out;
        for (int i = 0; i < 8; i++) begin
          repeat (10) @(negedge clk);
          b[i] = tx_wire_out;
        end
        repeat (10) @(negedge clk);
        s1 = tx_wire_out;
        if (mon_en) begin
          if (txq.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL tx_unexpected_byte: observed %02h expected none", b);
          end else begin
            e = txq.pop_front();
            chk("tx_byte", b, e[7:0]);
            chk("tx_start_bit", s0, 0);
            chk("tx_stop_bit", s1, 1);
            if (!e[8]) chk("tx_byte_spacing", st - last_st, 100);
          end
        end
        last_st = st;
      end
      tx_prev = tx_wire_out;
    end
  end

  always @(negedge clk) begin
    if (rst_in) begin
      if (valid_out) begin
        valid_seen++;
        chk("valid_one_cycle", valid_prev, 0);
        chk("valid_error_excl", error_out, 0);
        if (resq.size() == 0) begin
          checks++;
          errors++;
          $error("FAIL unexpected_valid: observed %08h expected none", result_out);
        end else chk("result", result_out, resq.pop_front());
      end
      if (error_out) err_seen++;
    end
    valid_prev = valid_out;
  end

  initial begin
    #300_000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_tx", tx_wire_out, 1);
    chk("rst_busy", busy_out, 0);
    chk("rst_valid", valid_out, 0);
    chk("rst_error", error_out, 0);
    chk("rst_result", result_out, 0);
    rst_in = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle_tx", tx_wire_out, 1);
    // Frame order and a good DE AD BE EF response.
    do_start(16'h0041, 32'h0001_0001, 32'h0000_0C8B);
    resq.push_back(32'hDEAD_BEEF);
    wait_tx_done();
    repeat (10) @(negedge clk);
    chk("recv_tx_idle", tx_wire_out, 1);
    chk("recv_busy", busy_out, 1);
    send_byte(8'hDE, 1'b1);
    send_byte(8'hAD, 1'b1);
    send_byte(8'hBE, 1'b1);
    send_byte(8'hEF, 1'b1);
    wait_busy_low();
    chk("result_valid_count", valid_seen, 1);
    chk("result_no_error", err_seen, 0);
    chk("result_value", result_out, 32'hDEAD_BEEF);
    // Silent responder; a byte during SEND must be ignored.
    do_start(16'h1234, 32'h0000_0003, 32'h0000_FFF1);
    repeat (100) @(negedge clk);
    send_byte(8'h99, 1'b1);
    n = 0;
    while (!error_out && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("timeout_cycles", cyc - c0, 1400);
    chk("timeout_busy", busy_out, 0);
    chk("timeout_result_kept", result_out, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("timeout_pulse_width", error_out, 0);
    chk("timeout_no_valid", valid_seen, 1);
    // Framing error on the second response byte.
    do_start(16'h0007, 32'h0000_0011, 32'h0000_00BB);
    wait_tx_done();
    repeat (10) @(negedge clk);
    e0 = err_seen;
    v0 = valid_seen;
    send_byte(8'h12, 1'b1);
    send_byte(8'h34, 1'b0);
    repeat (2) @(negedge clk);
    chk("frame_err_pulse", err_seen, e0 + 1);
    chk("frame_err_no_valid", valid_seen, v0);
    chk("frame_err_busy", busy_out, 0);
    chk("frame_err_result_kept", result_out, 32'hDEAD_BEEF);
    // False start glitch, then a good response.
    do_start(16'h0002, 32'h0000_0005, 32'h0000_0007);
    resq.push_back(32'h0123_4567);
    wait_tx_done();
    repeat (10) @(negedge clk);
    e0 = err_seen;
    v0 = valid_seen;
    rx_wire_in = 1'b0;
    repeat (3) @(negedge clk);
    rx_wire_in = 1'b1;
    repeat (30) @(negedge clk);
    chk("glitch_no_error", err_seen, e0);
    chk("glitch_no_valid", valid_seen, v0);
    chk("glitch_busy", busy_out, 1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h23, 1'b1);
    send_byte(8'h45, 1'b1);
    send_byte(8'h67, 1'b1);
    wait_busy_low();
    chk("glitch_valid", valid_seen, v0 + 1);
    chk("glitch_result", result_out, 32'h0123_4567);
    // start_in ignored while busy, then reset mid-SEND at bit 37.
    do_start(16'h0041, 32'h0001_0001, 32'h0000_0C8B);
    repeat (150) @(negedge clk);
    message_in = 16'hFFFF; exponent_in = 32'hAAAA_AAAA; modulus_in = 32'h5555_5555;
    start_in = 1'b1;
    @(negedge clk);
    start_in = 1'b0;
    chk("busy_start_ignored", busy_out, 1);
    repeat (224) @(negedge clk);
    chk("bit37_low", tx_wire_out, 0);
    chk("bytes_before_reset", txq.size(), 7);
    mon_en = 1'b0;
    txq.delete();
    rst_in = 1'b0;
    @(negedge clk);
    chk("mid_rst_tx", tx_wire_out, 1);
    chk("mid_rst_busy", busy_out, 0);
    chk("mid_rst_result", result_out, 0);
    chk("mid_rst_error", error_out, 0);
    repeat (3) @(negedge clk);
    rst_in = 1'b1;
    repeat (20) @(negedge clk);
    chk("post_rst_tx", tx_wire_out, 1);
    chk("post_rst_busy", busy_out, 0);
    chk("results_drained", resq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
